// File: rtl/wbu_stage.sv
// Write-back stage: queues completed instructions from the LSU in a small FIFO, then retires
// them one per cycle with load extension, register/CSR writes, a commit pulse and a retire counter.
module wbu_stage #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int CSRW  = 2,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid,
    output logic            wbu_ready,
    input  logic [XLEN-1:0] res,
    input  logic [XLEN-1:0] dataout,
    input  logic            memtoreg,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [2:0]      addr_lo,
    input  logic            regw,
    input  logic [RAW-1:0]  rd,
    input  logic            csrw,
    input  logic [CSRW-1:0] csr_idx,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_stall,
    output logic            regwen,
    output logic [RAW-1:0]  wa,
    output logic [XLEN-1:0] wd,
    output logic            csr_wen,
    output logic [CSRW-1:0] csr_wa,
    output logic [XLEN-1:0] csr_wd,
    output logic            commit,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     retire_cnt
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic [XLEN-1:0] dataout;
        logic            memtoreg;
        logic [1:0]      ld_size;
        logic            ld_unsigned;
        logic [2:0]      addr_lo;
        logic            regw;
        logic [RAW-1:0]  rd;
        logic            csrw;
        logic [CSRW-1:0] csr_idx;
        logic [XLEN-1:0] csr_wdata;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [63:0]     retire_cnt_q, retire_cnt_d;

    entry_t          in_entry;
    entry_t          head_e;
    logic            push;
    logic            pop;

    logic [2:0]      off;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign_bit;
    logic [XLEN-1:0] load_data;

    // Ready comes only from the registered count, so a full FIFO refuses a push even while popping.
    assign wbu_ready = (count_q != CNTW'(DEPTH));
    assign push      = lsu_valid & wbu_ready;
    assign pop       = (count_q != '0) & ~wb_stall;
    assign head_e    = mem_q[head_q];

    assign in_entry = '{res: res, dataout: dataout, memtoreg: memtoreg, ld_size: ld_size,
                        ld_unsigned: ld_unsigned, addr_lo: addr_lo, regw: regw, rd: rd,
                        csrw: csrw, csr_idx: csr_idx, csr_wdata: csr_wdata, pc: pc};

    always_comb begin
        mem_d        = mem_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        retire_cnt_d = retire_cnt_q;
        if (push) begin
            mem_d[tail_q] = in_entry;
            tail_d        = tail_q + PTRW'(1);
        end
        if (pop) begin
            head_d       = head_q + PTRW'(1);
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // On a 32-bit datapath the byte offset only spans a word, so bit 2 is masked off.
    always_comb begin
        off     = head_e.addr_lo & ((XLEN == 64) ? 3'b111 : 3'b011);
        shifted = head_e.dataout >> {off, 3'b000};
        mask     = '1;
        sign_bit = shifted[XLEN-1];
        case (head_e.ld_size)
            2'd0: begin
                mask     = XLEN'(8'hFF);
                sign_bit = shifted[7];
            end
            2'd1: begin
                mask     = XLEN'(16'hFFFF);
                sign_bit = shifted[15];
            end
            2'd2: begin
                mask     = XLEN'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                mask     = '1;
                sign_bit = shifted[XLEN-1];
            end
        endcase
        if (sign_bit && !head_e.ld_unsigned) begin
            load_data = shifted | ~mask;
        end else begin
            load_data = shifted & mask;
        end
    end

    assign regwen     = pop & head_e.regw & (head_e.rd != '0);
    assign wa         = head_e.rd;
    assign wd         = head_e.memtoreg ? load_data : head_e.res;
    assign csr_wen    = pop & head_e.csrw;
    assign csr_wa     = head_e.csr_idx;
    assign csr_wd     = head_e.csr_wdata;
    assign commit     = pop;
    assign commit_pc  = head_e.pc;
    assign retire_cnt = retire_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            mem_q        <= mem_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_wbu_stage.sv
// Directed bench for wbu_stage: ALU retire order, load extension, backpressure,
// x0/CSR writes, mid-stream reset and retire counter wrap.
module tb_wbu_stage;

    localparam int XLEN  = 32;
    localparam int RAW   = 5;
    localparam int CSRW  = 2;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            lsu_valid;
    logic            wbu_ready;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] dataout;
    logic            memtoreg;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [2:0]      addr_lo;
    logic            regw;
    logic [RAW-1:0]  rd;
    logic            csrw;
    logic [CSRW-1:0] csr_idx;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] pc;
    logic            wb_stall;
    logic            regwen;
    logic [RAW-1:0]  wa;
    logic [XLEN-1:0] wd;
    logic            csr_wen;
    logic [CSRW-1:0] csr_wa;
    logic [XLEN-1:0] csr_wd;
    logic            commit;
    logic [XLEN-1:0] commit_pc;
    logic [63:0]     retire_cnt;

    int          check_count = 0;
    int          pass_count  = 0;
    logic [63:0] exp_retire  = 64'd0;

    wbu_stage #(.XLEN(XLEN), .RAW(RAW), .CSRW(CSRW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .res(res), .dataout(dataout), .memtoreg(memtoreg), .ld_size(ld_size),
        .ld_unsigned(ld_unsigned), .addr_lo(addr_lo), .regw(regw), .rd(rd),
        .csrw(csrw), .csr_idx(csr_idx), .csr_wdata(csr_wdata), .pc(pc),
        .wb_stall(wb_stall), .regwen(regwen), .wa(wa), .wd(wd),
        .csr_wen(csr_wen), .csr_wa(csr_wa), .csr_wd(csr_wd), .commit(commit),
        .commit_pc(commit_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw, input logic [RAW-1:0] rdv,
                                 input logic cw, input logic [CSRW-1:0] idx,
                                 input logic [XLEN-1:0] cwd, input logic m2r,
                                 input logic [1:0] sz, input logic uns, input logic [2:0] alo,
                                 input logic [XLEN-1:0] resv, input logic [XLEN-1:0] dout,
                                 input logic [XLEN-1:0] pcv);
        lsu_valid   = v;
        regw        = rw;
        rd          = rdv;
        csrw        = cw;
        csr_idx     = idx;
        csr_wdata   = cwd;
        memtoreg    = m2r;
        ld_size     = sz;
        ld_unsigned = uns;
        addr_lo     = alo;
        res         = resv;
        dataout     = dout;
        pc          = pcv;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0, '0, '0, '0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]      ld_sz_v  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
    logic            ld_uns_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]      ld_off_v [8] = '{3'd1, 3'd3, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd4};
    logic [XLEN-1:0] ld_exp_v [8] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
                                      32'hFFFF_80FF, 32'h80FF_7F01, 32'h0000_7F01,
                                      32'h80FF_7F01, 32'h0000_0001};

    initial begin
        rst      = 1'b1;
        wb_stall = 1'b0;
        idleInputs();
        #3 rst = 1'b0;
        #9;
        checkOutput("reset_regwen", 64'(regwen), 64'd0);
        checkOutput("reset_commit", 64'(commit), 64'd0);
        checkOutput("reset_csr_wen", 64'(csr_wen), 64'd0);
        checkOutput("reset_retire_cnt", retire_cnt, 64'd0);
        checkOutput("reset_ready", 64'(wbu_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        nextCycle();

        // Back-to-back ALU results retire in order, one per cycle after the push edge.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, RAW'(i + 1), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                          XLEN'(32'h11 * (i + 1)), '0, XLEN'(32'h1000 + 4 * i));
            if (i == 0) begin
                checkOutput("alu_no_bypass", 64'(commit), 64'd0);
            end
            nextCycle();
            checkOutput($sformatf("alu%0d_regwen", i), 64'(regwen), 64'd1);
            checkOutput($sformatf("alu%0d_wa", i), 64'(wa), 64'(i + 1));
            checkOutput($sformatf("alu%0d_wd", i), 64'(wd), 64'(32'h11 * (i + 1)));
            checkOutput($sformatf("alu%0d_pc", i), 64'(commit_pc), 64'(32'h1000 + 4 * i));
            exp_retire++;
        end
        idleInputs();
        nextCycle();
        checkOutput("alu_drain_commit", 64'(commit), 64'd0);
        checkOutput("alu_retire_cnt", retire_cnt, exp_retire);

        // Load extension over a fixed memory word.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, RAW'(10), 1'b0, '0, '0, 1'b1, ld_sz_v[i], ld_uns_v[i],
                          ld_off_v[i], 32'hDEAD_BEEF, 32'h80FF_7F01, XLEN'(32'h1800 + 4 * i));
            nextCycle();
            checkOutput($sformatf("load%0d_wd", i), 64'(wd), 64'(ld_exp_v[i]));
            exp_retire++;
        end
        idleInputs();
        nextCycle();
        checkOutput("load_retire_cnt", retire_cnt, exp_retire);

        // Backpressure: stall fills the FIFO, then a full-cycle pop must not admit a push.
        wb_stall = 1'b1;
        applyStimulus(1'b1, 1'b1, RAW'(20), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hA0, '0, 32'h2000);
        checkOutput("bp_ready_empty", 64'(wbu_ready), 64'd1);
        nextCycle();
        checkOutput("bp_ready_one", 64'(wbu_ready), 64'd1);
        checkOutput("bp_stall_commit", 64'(commit), 64'd0);
        applyStimulus(1'b1, 1'b1, RAW'(21), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hB0, '0, 32'h2004);
        nextCycle();
        checkOutput("bp_ready_full", 64'(wbu_ready), 64'd0);
        applyStimulus(1'b1, 1'b1, RAW'(22), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hC0, '0, 32'h2008);
        nextCycle();
        checkOutput("bp_ready_held", 64'(wbu_ready), 64'd0);
        checkOutput("bp_regwen_held", 64'(regwen), 64'd0);
        wb_stall = 1'b0;
        #1;
        checkOutput("bp_ready_no_comb", 64'(wbu_ready), 64'd0);
        checkOutput("bp_pc_a", 64'(commit_pc), 64'h2000);
        checkOutput("bp_commit_a", 64'(commit), 64'd1);
        nextCycle();
        checkOutput("bp_pc_b", 64'(commit_pc), 64'h2004);
        checkOutput("bp_wd_b", 64'(wd), 64'hB0);
        checkOutput("bp_ready_after_pop", 64'(wbu_ready), 64'd1);
        nextCycle();
        checkOutput("bp_pc_c", 64'(commit_pc), 64'h2008);
        checkOutput("bp_commit_c", 64'(commit), 64'd1);
        idleInputs();
        nextCycle();
        checkOutput("bp_no_dup", 64'(commit), 64'd0);
        exp_retire += 3;
        checkOutput("bp_retire_cnt", retire_cnt, exp_retire);

        // x0 write is suppressed but the CSR write and commit still happen; then csrrw.
        applyStimulus(1'b1, 1'b1, RAW'(0), 1'b1, CSRW'(3), 32'h8000_0100, 1'b0, 2'd0, 1'b0,
                      3'd0, 32'h55, '0, 32'h3000);
        nextCycle();
        checkOutput("x0_regwen", 64'(regwen), 64'd0);
        checkOutput("x0_csr_wen", 64'(csr_wen), 64'd1);
        checkOutput("x0_csr_wa", 64'(csr_wa), 64'd3);
        checkOutput("x0_csr_wd", 64'(csr_wd), 64'h8000_0100);
        checkOutput("x0_commit", 64'(commit), 64'd1);
        applyStimulus(1'b1, 1'b1, RAW'(5), 1'b1, CSRW'(1), 32'h1888, 1'b0, 2'd0, 1'b0,
                      3'd0, 32'h77, '0, 32'h3004);
        nextCycle();
        checkOutput("csrrw_regwen", 64'(regwen), 64'd1);
        checkOutput("csrrw_wa", 64'(wa), 64'd5);
        checkOutput("csrrw_wd", 64'(wd), 64'h77);
        checkOutput("csrrw_csr_wen", 64'(csr_wen), 64'd1);
        checkOutput("csrrw_csr_wa", 64'(csr_wa), 64'd1);
        idleInputs();
        nextCycle();
        checkOutput("csr_idle_wen", 64'(csr_wen), 64'd0);
        exp_retire += 2;
        checkOutput("csr_retire_cnt", retire_cnt, exp_retire);

        // Mid-stream reset with two stalled entries queued.
        wb_stall = 1'b1;
        applyStimulus(1'b1, 1'b1, RAW'(7), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hD0, '0, 32'h4000);
        nextCycle();
        applyStimulus(1'b1, 1'b1, RAW'(8), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hE0, '0, 32'h4004);
        nextCycle();
        idleInputs();
        checkOutput("mid_full", 64'(wbu_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid_rst_regwen", 64'(regwen), 64'd0);
        checkOutput("mid_rst_commit", 64'(commit), 64'd0);
        checkOutput("mid_rst_retire_cnt", retire_cnt, 64'd0);
        checkOutput("mid_rst_ready", 64'(wbu_ready), 64'd1);
        wb_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_retire = 64'd0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("mid_dropped%0d_commit", i), 64'(commit), 64'd0);
            checkOutput($sformatf("mid_dropped%0d_regwen", i), 64'(regwen), 64'd0);
        end
        checkOutput("mid_retire_cnt", retire_cnt, exp_retire);

        // Counter wrap from all ones.
        force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.retire_cnt_q;
        #1;
        checkOutput("wrap_preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b1, 1'b1, RAW'(9), 1'b0, '0, '0, 1'b0, 2'd0, 1'b0, 3'd0,
                      32'hF0, '0, 32'h5000);
        nextCycle();
        idleInputs();
        checkOutput("wrap_commit", 64'(commit), 64'd1);
        nextCycle();
        checkOutput("wrap_retire_cnt", retire_cnt, 64'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
